seg7_bus_slave: RTL and testbench
=================================

Name: seg7_bus_slave

Overview:
- Register-mapped responder for the on-board dual-digit 7-segment display.
- Served by the same 8-bit CS/Write/Read/Address/Data/STRB/ack register bus that the top-level sequencer drives into the dot-matrix block.
- Accepts digit pattern writes and serialises each digit into the 74HC595-style shifter (seg_si/seg_sck/seg_rck).
- Time-multiplexes digit A and digit B via seg_a_en/seg_b_en.

Parameters:
- SCK_DIV, 4: seg_sck half-period in mclock cycles (>=1).
- DWELL, 50000: mclock cycles each digit stays enabled after latching (>=1).

Ports:
- mclock  in  1  system clock
- mreset  in  1  asynchronous, active-low reset
- CS  in  1  bus select
- Write  in  1  write request, qualified by CS
- Read  in  1  read request, qualified by CS
- Address  in  8  register address
- Data_i  in  8  write data
- STRB  in  4  byte-lane strobes; only STRB[0] used
- Data_o  out  8  read data
- ack  out  1  one-cycle transfer acknowledge
- seg_si  out  1  serial segment data to shifter
- seg_sck  out  1  shift clock
- seg_rck  out  1  latch clock
- seg_a_en  out  1  digit A enable
- seg_b_en  out  1  digit B enable

Behaviour:
- Reset (mreset=0, async): all registers 0x00; Data_o=0, ack=0; all seg_* outputs 0; FSM to IDLE.
- Register map:
  - 0x00 DIGA (rw)
  - 0x01 DIGB (rw)
  - 0x02 CTRL (rw): bit0 EN, bit1 HEX; other bits read 0.
  - 0x03 STAT (ro): bit0 BUSY = FSM not IDLE; bit1 CUR = digit currently selected (0=A, 1=B).
  - Other addresses: read 0x00, writes ignored.
- Bus handshake:
  - A request is CS=1 with Write=1 or Read=1, sampled at posedge N.
  - ack=1 for exactly cycle N+1, and Data_o is valid in that same cycle. Data_o=0 whenever ack=0.
  - Each cycle with a request generates its own ack, so CS held high for K cycles yields K acks.
  - Write takes effect only if STRB[0]=1; ack is returned regardless of STRB.
  - Write and Read both high: treated as a write; Data_o=0x00.
  - Writes to STAT are acked and ignored.
- Scan FSM: IDLE -> LOAD -> SHIFT -> LATCH -> SHOW -> LOAD...
  - IDLE: all seg_* outputs 0. Moves to LOAD when EN=1, starting with digit A.
  - LOAD (1 cycle): snapshots DIGA or DIGB (per current digit) into the shift register; both enables 0. Bus writes after the snapshot affect only the next visit.
  - SHIFT: 8 bits, MSB first.
    - seg_si changes while seg_sck=0.
    - seg_sck is low for SCK_DIV cycles, then high for SCK_DIV cycles, per bit.
    - Total 16*SCK_DIV cycles; seg_sck ends low.
  - LATCH: seg_rck=1 for SCK_DIV cycles.
  - SHOW:
    - Enables the current digit's seg_x_en for DWELL cycles.
    - Then drops the enable, toggles the current digit, and returns to LOAD.
    - The A and B enables are never both 1.
- EN cleared mid-scan: at the next posedge the FSM goes to IDLE, and all seg_* outputs are 0 on the following cycle. On re-enable the scan restarts with digit A.
- Counters saturate at their terminal values; there are no wrap-around glitches between digits.

Optional Feature:
- SEG7_HEX_DECODE_EN
- When defined and CTRL.HEX=1, LOAD passes the low nibble through a hex-to-segment decoder:
  - Bit order {dp,g,f,e,d,c,b,a}, 1 = lit.
  - Examples: 0x0->0x3F, 0x8->0x7F, 0xA->0x77, 0xF->0x71.
  - Data bit7 is copied to dp.
- When not defined: CTRL bit1 is not implemented (reads 0, writes ignored) and patterns are shifted raw.

Test Plan:
- Bench uses SCK_DIV=2, DWELL=16 throughout.
- Reset values: assert mreset=0 mid-SHIFT -> all outputs 0 immediately; read 0x02 after release -> ack one cycle after the request, Data_o=0x00.
- Raw scan: write DIGA=0xA5, DIGB=0x3C, CTRL=0x01 -> seg_si sequence 1,0,1,0,0,1,0,1 over 8 seg_sck rising edges; seg_rck high 2 cycles; seg_a_en high 16 cycles; then 0x3C shifted followed by seg_b_en; never both enables high.
- Handshake and strobes:
  - Write 0x00=0x55 with STRB=0000 -> ack, DIGA remains 0x00.
  - With STRB=0001 -> DIGA=0x55.
  - Read 0x07 -> Data_o=0x00 with ack.
  - CS held high for 3 Read cycles -> 3 acks.
- Snapshot: write DIGA=0xFF during SHIFT of digit A (old value 0x00) -> current frame shifts 0x00; next A frame shifts 0xFF.
- Disable mid-frame: clear EN during SHOW -> all seg_* outputs 0 within 2 cycles; STAT reads 0x00; re-enable -> first LOAD selects digit A.
- Hex decode (macro defined): CTRL=0x03, DIGA=0x8A -> shifted pattern 0xF7; without the macro, CTRL reads back 0x01 and 0x8A is shifted raw.

Source files
------------

// File: rtl/seg7_bus_slave.sv
// Register-mapped dual-digit 7-segment driver: bus slave plus 595-style serial scan FSM.
// Optional build macro SEG7_HEX_DECODE_EN adds CTRL.HEX nibble-to-segment decoding.
module seg7_bus_slave #(
  parameter int SCK_DIV = 4,
  parameter int DWELL   = 50000
) (
  input  logic       mclock,
  input  logic       mreset,
  input  logic       CS,
  input  logic       Write,
  input  logic       Read,
  input  logic [7:0] Address,
  input  logic [7:0] Data_i,
  input  logic [3:0] STRB,
  output logic [7:0] Data_o,
  output logic       ack,
  output logic       seg_si,
  output logic       seg_sck,
  output logic       seg_rck,
  output logic       seg_a_en,
  output logic       seg_b_en
);

  localparam int CMAX = (DWELL > 2*SCK_DIV) ? DWELL : 2*SCK_DIV;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, SHOW} state_t;

  state_t          state, state_nxt;
  logic [7:0]      diga, digb, shreg, rdata, cur_dig, load_pat;
  logic            ctrl_en, ctrl_hex, cur;
  logic [CW-1:0]   cnt;
  logic [2:0]      bitn;
  logic            req, wr, bit_end, lat_end, show_end;
  logic            unused_strb;

  assign req         = CS & (Write | Read);
  assign wr          = CS & Write;
  assign unused_strb = ^STRB[3:1];

  always_comb begin
    rdata = 8'h00;
    case (Address)
      8'h00:   rdata = diga;
      8'h01:   rdata = digb;
      8'h02:   rdata = {6'b0, ctrl_hex, ctrl_en};
      8'h03:   rdata = {6'b0, cur, state != IDLE};
      default: rdata = 8'h00;
    endcase
  end

  // Write wins over read when both are asserted; read data is zero in that case.
  always_ff @(posedge mclock or negedge mreset) begin
    if (!mreset) begin
      ack     <= 1'b0;
      Data_o  <= 8'h00;
      diga    <= 8'h00;
      digb    <= 8'h00;
      ctrl_en <= 1'b0;
`ifdef SEG7_HEX_DECODE_EN
      ctrl_hex <= 1'b0;
`endif
    end else begin
      ack    <= req;
      Data_o <= (req && !Write) ? rdata : 8'h00;
      if (wr && STRB[0]) begin
        case (Address)
          8'h00: diga <= Data_i;
          8'h01: digb <= Data_i;
          8'h02: begin
            ctrl_en <= Data_i[0];
`ifdef SEG7_HEX_DECODE_EN
            ctrl_hex <= Data_i[1];
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign cur_dig = cur ? digb : diga;

`ifdef SEG7_HEX_DECODE_EN
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign load_pat = ctrl_hex ? {cur_dig[7], hex7(cur_dig[3:0])} : cur_dig;
`else
  assign ctrl_hex = 1'b0;
  assign load_pat = cur_dig;
`endif

  assign bit_end  = (cnt == CW'(2*SCK_DIV - 1));
  assign lat_end  = (cnt == CW'(SCK_DIV - 1));
  assign show_end = (cnt == CW'(DWELL - 1));

  always_comb begin
    state_nxt = state;
    seg_si    = 1'b0;
    seg_sck   = 1'b0;
    seg_rck   = 1'b0;
    seg_a_en  = 1'b0;
    seg_b_en  = 1'b0;
    case (state)
      IDLE:  if (ctrl_en) state_nxt = LOAD;
      LOAD:  state_nxt = SHIFT;
      SHIFT: begin
        seg_si  = shreg[7];
        seg_sck = (cnt >= CW'(SCK_DIV));
        if (bit_end && bitn == 3'd7) state_nxt = LATCH;
      end
      LATCH: begin
        seg_rck = 1'b1;
        if (lat_end) state_nxt = SHOW;
      end
      SHOW: begin
        seg_a_en = ~cur;
        seg_b_en = cur;
        if (show_end) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
    if (!ctrl_en) state_nxt = IDLE;
  end

  // Any exit to IDLE clears the digit select so a re-enable always starts on A.
  always_ff @(posedge mclock or negedge mreset) begin
    if (!mreset) begin
      state <= IDLE;
      shreg <= 8'h00;
      cnt   <= '0;
      bitn  <= 3'd0;
      cur   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == IDLE) begin
        cnt  <= '0;
        bitn <= 3'd0;
        cur  <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            shreg <= load_pat;
            cnt   <= '0;
            bitn  <= 3'd0;
          end
          SHIFT: begin
            if (bit_end) begin
              cnt   <= '0;
              shreg <= {shreg[6:0], 1'b0};
              if (bitn != 3'd7) bitn <= bitn + 3'd1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          LATCH: cnt <= lat_end ? '0 : cnt + 1'b1;
          SHOW: begin
            if (show_end) begin
              cnt <= '0;
              cur <= ~cur;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_bus_slave.sv
// Scoreboard bench for seg7_bus_slave: bus acks and scanned frames checked against a register-level model.
module tb_seg7_bus_slave;
  localparam int SCK_DIV = 2;
  localparam int DWELL   = 16;

  logic       mclock = 0, mreset = 0;
  logic       CS = 0, Write = 0, Read = 0;
  logic [7:0] Address = 0, Data_i = 0;
  logic [3:0] STRB = 0;
  logic [7:0] Data_o;
  logic       ack, seg_si, seg_sck, seg_rck, seg_a_en, seg_b_en;

  seg7_bus_slave #(.SCK_DIV(SCK_DIV), .DWELL(DWELL)) dut (
    .mclock(mclock), .mreset(mreset), .CS(CS), .Write(Write), .Read(Read),
    .Address(Address), .Data_i(Data_i), .STRB(STRB), .Data_o(Data_o), .ack(ack),
    .seg_si(seg_si), .seg_sck(seg_sck), .seg_rck(seg_rck),
    .seg_a_en(seg_a_en), .seg_b_en(seg_b_en));

  always #5 mclock = ~mclock;

  typedef struct packed { logic dig; logic [7:0] pat; } frame_t;

  int         total = 0, bad = 0, ack_cnt = 0, both_hi = 0;
  logic [7:0] exp_bus[$];
  frame_t     exp_fr[$];
  logic [7:0] m_diga = 0, m_digb = 0, m_ctrl = 0;
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef SEG7_HEX_DECODE_EN
  localparam logic [7:0] CMASK = 8'h03;
`else
  localparam logic [7:0] CMASK = 8'h01;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s got=%0h want=none at %0t", name, act, $time);
  endtask

  // STAT is only read while scanning is disabled, where it must be zero.
  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return m_diga;
      8'h01:   return m_digb;
      8'h02:   return m_ctrl;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_pat(input logic [7:0] v);
    logic [7:0] r;
    r = v;
`ifdef SEG7_HEX_DECODE_EN
    if (m_ctrl[1]) r = {v[7], seg_tab[v[3:0]]};
`endif
    return r;
  endfunction

  task automatic bus_op(input logic w, input logic r, input logic [7:0] a,
                        input logic [7:0] d, input logic [3:0] s);
    @(negedge mclock);
    CS = 1; Write = w; Read = r; Address = a; Data_i = d; STRB = s;
    exp_bus.push_back(w ? 8'h00 : model_read(a));
    if (w && s[0]) begin
      case (a)
        8'h00: m_diga = d;
        8'h01: m_digb = d;
        8'h02: m_ctrl = d & CMASK;
        default: ;
      endcase
    end
    @(negedge mclock);
    CS = 0; Write = 0; Read = 0;
    chk("ack_latency", ack, 1);
    @(negedge mclock);
  endtask

  task automatic wait_frames();
    for (int i = 0; i < 3000 && exp_fr.size() != 0; i++) @(negedge mclock);
    chk("frames_done", exp_fr.size(), 0);
  endtask

  task automatic wait_sig(input int which, input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge mclock);
      if ((which == 0 && seg_sck) || (which == 1 && seg_b_en)) break;
    end
    if (i == 300) flag(name, 0);
  endtask

  // Bus scoreboard: every ack pops one expected read word.
  always @(negedge mclock) begin
    if (mreset) begin
      if (ack) begin
        ack_cnt++;
        if (exp_bus.size() == 0) flag("ack_unexpected", Data_o);
        else chk("rdata", Data_o, exp_bus.pop_front());
      end else if (Data_o != 8'h00) begin
        flag("data_idle", Data_o);
      end
    end
  end

  // Frame monitor: reassembles shifted byte, latch width and dwell per digit.
  logic [7:0] win, latched;
  int         rck_len, rck_seen, en_len;
  logic       prev_sck, prev_rck, prev_en, en_dig;
  always @(negedge mclock or negedge mreset) begin
    if (!mreset) begin
      win = 0; latched = 0; rck_len = 0; rck_seen = 0; en_len = 0;
      prev_sck = 0; prev_rck = 0; prev_en = 0; en_dig = 0;
    end else begin
      frame_t f;
      if (seg_a_en && seg_b_en) both_hi++;
      if (seg_sck && !prev_sck) win = {win[6:0], seg_si};
      if (seg_rck) rck_len++;
      else if (prev_rck) begin
        latched = win; rck_seen = rck_len; rck_len = 0;
      end
      if (seg_a_en || seg_b_en) begin
        en_len++; en_dig = seg_b_en;
      end else if (prev_en) begin
        if (exp_fr.size() != 0) begin
          f = exp_fr.pop_front();
          chk("frame_digit", en_dig, f.dig);
          chk("frame_pattern", latched, f.pat);
          chk("dwell", en_len, DWELL);
          chk("rck_width", rck_seen, SCK_DIV);
        end
        en_len = 0;
      end
      prev_sck = seg_sck; prev_rck = seg_rck; prev_en = seg_a_en | seg_b_en;
    end
  end

  initial begin
    int acks0;
    logic [7:0] rb, a, d;
    logic w, r;
    repeat (3) @(negedge mclock);
    chk("reset_out", {ack, Data_o, seg_si, seg_sck, seg_rck, seg_a_en, seg_b_en}, 0);
    mreset = 1;

    // Async reset in the middle of a shift
    bus_op(1, 0, 8'h00, 8'hA5, 4'h1);
    bus_op(1, 0, 8'h02, 8'h01, 4'h1);
    wait_sig(0, "wait_sck");
    #2 mreset = 0;
    #1 chk("async_reset_out", {ack, Data_o, seg_si, seg_sck, seg_rck, seg_a_en, seg_b_en}, 0);
    m_diga = 0; m_digb = 0; m_ctrl = 0;
    exp_bus.delete(); exp_fr.delete();
    repeat (2) @(negedge mclock);
    mreset = 1;
    bus_op(0, 1, 8'h02, 8'h00, 4'h0);
    bus_op(0, 1, 8'h00, 8'h00, 4'h0);

    // Handshake and strobes
    bus_op(1, 0, 8'h00, 8'h55, 4'h0);
    bus_op(0, 1, 8'h00, 8'h00, 4'h0);
    bus_op(1, 0, 8'h00, 8'h55, 4'h1);
    bus_op(0, 1, 8'h00, 8'h00, 4'h0);
    bus_op(0, 1, 8'h07, 8'h00, 4'h0);
    bus_op(1, 0, 8'h03, 8'hFF, 4'h1);
    bus_op(0, 1, 8'h03, 8'h00, 4'h0);
    bus_op(1, 1, 8'h01, 8'h9C, 4'h1);
    bus_op(0, 1, 8'h01, 8'h00, 4'h0);
    acks0 = ack_cnt;
    @(negedge mclock);
    CS = 1; Read = 1; Address = 8'h01;
    repeat (3) exp_bus.push_back(m_digb);
    repeat (3) @(negedge mclock);
    CS = 0; Read = 0;
    repeat (2) @(negedge mclock);
    chk("burst_acks", ack_cnt - acks0, 3);

    // Random register traffic with scanning kept off
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 7));
      d = 8'($urandom);
      if (a == 8'h02) d[0] = 1'b0;
      case ($urandom_range(0, 2))
        0: begin w = 1; r = 0; end
        1: begin w = 0; r = 1; end
        default: begin w = 1; r = 1; end
      endcase
      bus_op(w, r, a, d, 4'($urandom));
    end

    // Raw scan A then B then A
    bus_op(1, 0, 8'h00, 8'hA5, 4'h1);
    bus_op(1, 0, 8'h01, 8'h3C, 4'h1);
    bus_op(1, 0, 8'h02, 8'h01, 4'h1);
    exp_fr.push_back('{1'b0, exp_pat(8'hA5)});
    exp_fr.push_back('{1'b1, exp_pat(8'h3C)});
    exp_fr.push_back('{1'b0, exp_pat(8'hA5)});
    wait_frames();

    // Disable during digit B dwell
    wait_sig(1, "wait_b_en");
    repeat (3) @(negedge mclock);
    bus_op(1, 0, 8'h02, 8'h00, 4'h1);
    chk("disable_out", {seg_si, seg_sck, seg_rck, seg_a_en, seg_b_en}, 0);
    bus_op(0, 1, 8'h03, 8'h00, 4'h0);

    // Snapshot: DIGA write during its own shift only affects the next A frame
    rb = 8'($urandom);
    bus_op(1, 0, 8'h00, 8'h00, 4'h1);
    bus_op(1, 0, 8'h01, rb, 4'h1);
    bus_op(1, 0, 8'h02, 8'h01, 4'h1);
    exp_fr.push_back('{1'b0, exp_pat(8'h00)});
    exp_fr.push_back('{1'b1, exp_pat(rb)});
    exp_fr.push_back('{1'b0, exp_pat(8'hFF)});
    wait_sig(0, "wait_sck2");
    bus_op(1, 0, 8'h00, 8'hFF, 4'h1);
    wait_frames();

    // Hex decode option
    bus_op(1, 0, 8'h02, 8'h00, 4'h1);
    bus_op(1, 0, 8'h00, 8'h8A, 4'h1);
    bus_op(1, 0, 8'h02, 8'h03, 4'h1);
    bus_op(0, 1, 8'h02, 8'h00, 4'h0);
    exp_fr.push_back('{1'b0, exp_pat(8'h8A)});
    wait_frames();
    bus_op(1, 0, 8'h02, 8'h00, 4'h1);
    repeat (4) @(negedge mclock);

    chk("bus_queue_empty", exp_bus.size(), 0);
    chk("both_enables", both_hi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
